// File: rtl/bbot_encoder_sample_scheduler.sv
// Encoder sample scheduler: periodically snapshots NUM_CH 32-bit quadrature counts and
// streams one {channel, count, delta, seq} record per channel over a valid/ready handshake.
// The first tick after reset or after enable rises only primes the previous-snapshot bank.
module bbot_encoder_sample_scheduler #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 3,
  parameter int unsigned PERIOD = 50000,
  parameter int unsigned PER_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NUM_CH*32-1:0] count_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_channel,
  output logic [31:0]          out_count,
  output logic [31:0]          out_delta,
  output logic [7:0]           out_seq,
  output logic                 overrun,
  input  logic                 overrun_clear
);

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  localparam logic [PER_W-1:0] TimerLast = PER_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  ChLast    = CH_W'(NUM_CH - 1);

  state_e             state_q, state_d;
  logic [PER_W-1:0]   timer_q, timer_d;
  logic               primed_q, primed_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [7:0]         seq_q, seq_d;
  logic               overrun_q, overrun_d;
  logic [31:0]        snap_q [NUM_CH];
  logic [31:0]        snap_d [NUM_CH];
  logic [31:0]        prev_q [NUM_CH];
  logic [31:0]        prev_d [NUM_CH];

  logic               tick;
  logic [31:0]        sel_snap;
  logic [31:0]        sel_prev;

  assign tick = enable && (timer_q == TimerLast);

  // Period timer: free-runs 0..PERIOD-1 while enabled, parked at zero otherwise.
  always_comb begin
    timer_d = timer_q;
    if (!enable) begin
      timer_d = '0;
    end else if (timer_q == TimerLast) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + PER_W'(1);
    end
  end

  // Frame sequencing, snapshot capture, prev update on handshake and sticky overrun.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    seq_d     = seq_q;
    primed_d  = primed_q;
    overrun_d = overrun_q;
    snap_d    = snap_q;
    prev_d    = prev_q;

    // A dropped tick below overrides the clear, so set wins on a collision.
    if (overrun_clear) begin
      overrun_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          for (int k = 0; k < NUM_CH; k++) begin
            snap_d[k] = count_in[32*k +: 32];
          end
          if (!primed_q) begin
            // Priming tick: establish the delta baseline, emit nothing.
            for (int k = 0; k < NUM_CH; k++) begin
              prev_d[k] = count_in[32*k +: 32];
            end
            primed_d = 1'b1;
          end else begin
            state_d = StEmit;
            ch_d    = '0;
          end
        end
      end
      StEmit: begin
        // Tick during a frame is dropped; snap and prev stay as they are.
        if (tick) begin
          overrun_d = 1'b1;
        end
        if (out_ready) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (CH_W'(k) == ch_q) begin
              prev_d[k] = snap_q[k];
            end
          end
          if (ch_q == ChLast) begin
            state_d = StIdle;
            ch_d    = '0;
            seq_d   = seq_q + 8'd1;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (!enable) begin
      primed_d = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      primed_q  <= 1'b0;
      ch_q      <= '0;
      seq_q     <= '0;
      overrun_q <= 1'b0;
      snap_q    <= '{default: '0};
      prev_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      primed_q  <= primed_d;
      ch_q      <= ch_d;
      seq_q     <= seq_d;
      overrun_q <= overrun_d;
      snap_q    <= snap_d;
      prev_q    <= prev_d;
    end
  end

  // Select the current channel's snapshot pair without a raw variable-width array index.
  always_comb begin
    sel_snap = '0;
    sel_prev = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (CH_W'(k) == ch_q) begin
        sel_snap = snap_q[k];
        sel_prev = prev_q[k];
      end
    end
  end

  assign out_valid   = (state_q == StEmit);
  assign out_channel = ch_q;
  assign out_count   = sel_snap;
  assign out_delta   = sel_snap - sel_prev;
  assign out_seq     = seq_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_bbot_encoder_sample_scheduler.sv
// Scoreboard bench for the encoder sample scheduler (PERIOD=8, NUM_CH=2).
// Stimulus pushes hand-computed records; a negedge monitor compares every presented record.
module tb_bbot_encoder_sample_scheduler;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned CH_W   = 3;
  localparam int unsigned PERIOD = 8;
  localparam int unsigned PER_W  = 4;

  logic                 clock;
  logic                 reset;
  logic                 enable;
  logic [NUM_CH*32-1:0] count_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [CH_W-1:0]      out_channel;
  logic [31:0]          out_count;
  logic [31:0]          out_delta;
  logic [7:0]           out_seq;
  logic                 overrun;
  logic                 overrun_clear;

  typedef struct {
    logic [31:0] ch;
    logic [31:0] cnt;
    logic [31:0] dlt;
    logic [31:0] seq;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  bbot_encoder_sample_scheduler #(
    .NUM_CH(NUM_CH),
    .CH_W  (CH_W),
    .PERIOD(PERIOD),
    .PER_W (PER_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .count_in     (count_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_channel  (out_channel),
    .out_count    (out_count),
    .out_delta    (out_delta),
    .out_seq      (out_seq),
    .overrun      (overrun),
    .overrun_clear(overrun_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [31:0] ch, input logic [31:0] cnt, input logic [31:0] dlt,
                      input logic [31:0] seq);
    exp_t e;
    e.ch  = ch;
    e.cnt = cnt;
    e.dlt = dlt;
    e.seq = seq;
    exp_q.push_back(e);
  endtask

  task automatic set_counts(input logic [31:0] c0, input logic [31:0] c1);
    count_in = {c1, c0};
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every presented record must match the queue head; pop on handshake.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_record: ch %0d count 0x%08h delta 0x%08h, none expected",
                   out_channel, out_count, out_delta);
        end else begin
          mon_e = exp_q[0];
          chk("rec_channel", 32'(out_channel), mon_e.ch);
          chk("rec_count", out_count, mon_e.cnt);
          chk("rec_delta", out_delta, mon_e.dlt);
          chk("rec_seq", 32'(out_seq), mon_e.seq);
          if (out_ready) begin
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset         = 1'b1;
    enable        = 1'b0;
    count_in      = '0;
    out_ready     = 1'b1;
    overrun_clear = 1'b0;

    // Reset values.
    cycles(3);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_channel", 32'(out_channel), 32'd0);
    chk("rst_count", out_count, 32'd0);
    chk("rst_delta", out_delta, 32'd0);
    chk("rst_seq", 32'(out_seq), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // Priming: E0 is this point; ticks land on E8, E16, ...
    reset  = 1'b0;
    enable = 1'b1;
    set_counts(32'h8000_0000, 32'h8000_0000);
    cycles(8);                                     // E8: priming tick
    chk("prime_no_valid", 32'(out_valid), 32'd0);
    set_counts(32'h8000_0005, 32'h7FFF_FFFD);
    push(0, 32'h8000_0005, 32'h0000_0005, 0);
    push(1, 32'h7FFF_FFFD, 32'hFFFF_FFFD, 0);
    cycles(8);                                     // E16: first frame
    chk("f0_valid_ch0", 32'(out_valid), 32'd1);
    chk("f0_ch0_index", 32'(out_channel), 32'd0);
    set_counts(32'h8000_0010, 32'h7FFF_FFF0);
    push(0, 32'h8000_0010, 32'h0000_000B, 1);
    push(1, 32'h7FFF_FFF0, 32'hFFFF_FFF3, 1);
    cycles(1);                                     // E17
    chk("f0_ch1_next_cycle", 32'(out_channel), 32'd1);
    cycles(1);                                     // E18
    chk("f0_done_valid", 32'(out_valid), 32'd0);
    chk("f0_seq_incr", 32'(out_seq), 32'd1);

    // Backpressure: ready low for 3 cycles after valid rises at E24.
    out_ready = 1'b0;
    cycles(6);                                     // E24
    chk("bp_valid", 32'(out_valid), 32'd1);
    cycles(3);                                     // E27
    chk("bp_hold_channel", 32'(out_channel), 32'd0);
    chk("bp_hold_count", out_count, 32'h8000_0010);
    out_ready = 1'b1;
    cycles(1);                                     // E28
    chk("bp_ch1", 32'(out_channel), 32'd1);
    cycles(1);                                     // E29
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_seq", 32'(out_seq), 32'd2);
    chk("no_overrun_yet", 32'(overrun), 32'd0);

    // Overrun: ready low E33..E44, tick at E40 dropped.
    set_counts(32'h8000_0020, 32'h7FFF_FFE0);
    push(0, 32'h8000_0020, 32'h0000_0010, 2);
    push(1, 32'h7FFF_FFE0, 32'hFFFF_FFF0, 2);
    cycles(3);                                     // E32
    out_ready = 1'b0;
    set_counts(32'h8000_0030, 32'h7FFF_FFD0);      // would be captured at E40 if not dropped
    cycles(12);                                    // E44
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_orig_snapshot", out_count, 32'h8000_0020);
    set_counts(32'h8000_0045, 32'h7FFF_FFC0);
    push(0, 32'h8000_0045, 32'h0000_0025, 3);
    push(1, 32'h7FFF_FFC0, 32'hFFFF_FFE0, 3);
    out_ready     = 1'b1;
    overrun_clear = 1'b1;
    cycles(1);                                     // E45
    overrun_clear = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Wrap: ch0 goes 0xFFFFFFFE -> 0x00000001.
    cycles(3);                                     // E48: frame seq3
    set_counts(32'hFFFF_FFFE, 32'h7FFF_FFC0);
    push(0, 32'hFFFF_FFFE, 32'h7FFF_FFB9, 4);
    push(1, 32'h7FFF_FFC0, 32'h0000_0000, 4);
    cycles(2);                                     // E50
    chk("seq4_pending", 32'(out_seq), 32'd4);
    cycles(6);                                     // E56: frame seq4
    set_counts(32'h0000_0001, 32'h7FFF_FFC1);
    push(0, 32'h0000_0001, 32'h0000_0003, 5);
    push(1, 32'h7FFF_FFC1, 32'h0000_0001, 5);
    cycles(8);                                     // E64: frame seq5

    // Enable toggle mid-frame.
    set_counts(32'h0000_0011, 32'h7FFF_FFC1);
    push(0, 32'h0000_0011, 32'h0000_0010, 6);
    push(1, 32'h7FFF_FFC1, 32'h0000_0000, 6);
    cycles(8);                                     // E72: frame seq6
    chk("en_frame_valid", 32'(out_valid), 32'd1);
    enable    = 1'b0;
    out_ready = 1'b0;
    cycles(2);                                     // E74
    chk("en_timer_zero", 32'(dut.timer_q), 32'd0);
    chk("en_frame_held", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cycles(2);                                     // E76
    chk("en_frame_done", 32'(out_valid), 32'd0);
    chk("en_seq", 32'(out_seq), 32'd7);
    cycles(10);                                    // E86
    chk("en_no_ticks", 32'(out_valid), 32'd0);
    chk("en_timer_idle", 32'(dut.timer_q), 32'd0);
    enable = 1'b1;
    set_counts(32'h0000_0100, 32'h0000_0200);
    cycles(8);                                     // E94: priming tick only
    chk("reen_prime_only", 32'(out_valid), 32'd0);
    set_counts(32'h0000_0105, 32'h0000_01FF);
    push(0, 32'h0000_0105, 32'h0000_0005, 7);
    push(1, 32'h0000_01FF, 32'hFFFF_FFFF, 7);
    cycles(8);                                     // E102: frame seq7
    chk("reen_frame_valid", 32'(out_valid), 32'd1);

    // Reset mid-frame while ch1 is presented.
    set_counts(32'h0000_010A, 32'h0000_01FF);
    push(0, 32'h0000_010A, 32'h0000_0005, 8);
    push(1, 32'h0000_01FF, 32'h0000_0000, 8);
    cycles(8);                                     // E110: frame seq8
    chk("rstm_valid_ch0", 32'(out_valid), 32'd1);
    cycles(1);                                     // E111
    chk("rstm_on_ch1", 32'(out_channel), 32'd1);
    out_ready = 1'b0;
    reset     = 1'b1;
    cycles(1);                                     // E112
    chk("rstm_valid_low", 32'(out_valid), 32'd0);
    chk("rstm_seq_zero", 32'(out_seq), 32'd0);
    chk("rstm_channel_zero", 32'(out_channel), 32'd0);
    exp_q.delete();                                // ch1 record discarded by reset
    reset     = 1'b0;
    out_ready = 1'b1;
    cycles(8);                                     // E120: priming tick after reset
    chk("rstm_prime_only", 32'(out_valid), 32'd0);
    cycles(4);
    chk("rstm_still_idle", 32'(out_valid), 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
